// File: rtl/program_loader.sv
// Program-memory loader: turns a little-endian byte stream into 32-bit words
// and issues one write per word at incrementing byte addresses.
module program_loader #(
  parameter int          MEMORY_DEPTH = 32,
  parameter int          DATA_WIDTH   = 32,
  parameter logic [31:0] BASE_ADDRESS = 32'h0040_0000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start_i,
  input  logic [$clog2(MEMORY_DEPTH):0] word_count_i,
  input  logic                          byte_valid_i,
  input  logic [7:0]                    byte_data_i,
  output logic                          byte_ready_o,
  output logic                          mem_we_o,
  output logic [DATA_WIDTH-1:0]         mem_addr_o,
  output logic [DATA_WIDTH-1:0]         mem_data_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          error_o
);

  localparam int CW = $clog2(MEMORY_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(MEMORY_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic                  err_q, err_d;
  logic                  accept;
  logic                  count_bad;

  assign accept    = byte_valid_i && byte_ready_o;
  assign count_bad = (word_count_i == '0) || (word_count_i > DEPTH_C);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    addr_d  = addr_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (count_bad) begin
            err_d = 1'b1;
          end else begin
            err_d   = 1'b0;
            cnt_d   = word_count_i;
            addr_d  = DATA_WIDTH'(BASE_ADDRESS);
            idx_d   = 2'd0;
            state_d = RECV;
          end
        end
      end
      RECV: begin
        if (accept) begin
          buf_d[{idx_q, 3'b000} +: 8] = byte_data_i;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = WRITE;
        end
      end
      WRITE: begin
        // Address and count advance as the write leaves; the strobe cycle sees the old address.
        addr_d  = addr_q + DATA_WIDTH'(4);
        cnt_d   = cnt_q - CW'(1);
        idx_d   = 2'd0;
        state_d = (cnt_q == CW'(1)) ? DONE : RECV;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  // Handshake and status flags are registered copies of the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_ready_o <= 1'b0;
      mem_we_o     <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      byte_ready_o <= (state_d == RECV);
      mem_we_o     <= (state_d == WRITE);
      busy_o       <= (state_d == RECV) || (state_d == WRITE);
      done_o       <= (state_d == DONE);
    end
  end

  assign mem_addr_o = addr_q;
  assign mem_data_o = buf_q;
  assign error_o    = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader.
module tb_program_loader;

  logic        clk;
  logic        reset;
  logic        start_i;
  logic [5:0]  word_count_i;
  logic        byte_valid_i;
  logic [7:0]  byte_data_i;
  logic        byte_ready_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        busy_o;
  logic        done_o;
  logic        error_o;

  int errors = 0;
  int checks = 0;

  logic [7:0]  stream [0:127];
  logic [31:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  logic [7:0]  cons_q [$];
  int          done_cnt = 0;
  int          we_wide  = 0;
  logic        we_prev  = 1'b0;

  program_loader dut (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start_i),
    .word_count_i (word_count_i),
    .byte_valid_i (byte_valid_i),
    .byte_data_i  (byte_data_i),
    .byte_ready_o (byte_ready_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .error_o      (error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we_o) begin
      wr_addr_q.push_back(mem_addr_o);
      wr_data_q.push_back(mem_data_o);
    end
    if (mem_we_o && we_prev) we_wide++;
    we_prev = mem_we_o;
    if (done_o) done_cnt++;
  end

  always @(posedge clk) begin
    if (reset && byte_valid_i && byte_ready_o) cons_q.push_back(byte_data_i);
  end

  task automatic do_start(input logic [5:0] cnt);
    @(negedge clk);
    start_i = 1'b1;
    word_count_i = cnt;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic send_stream(input int n, input bit stall);
    int to;
    for (int i = 0; i < n; i++) begin
      if (stall) begin
        int g;
        g = $urandom_range(0, 3);
        repeat (g) begin
          @(negedge clk);
          byte_valid_i = 1'b0;
        end
      end
      @(negedge clk);
      byte_valid_i = 1'b1;
      byte_data_i = stream[i];
      to = 0;
      while (!byte_ready_o && to < 50) begin
        @(negedge clk);
        to++;
      end
      if (to >= 50) begin
        checks++; errors++;
        $display("FAIL byte_accept_timeout: byte %0d never accepted, ready=%0b required 1", i, byte_ready_o);
      end
    end
    @(negedge clk);
    byte_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen, output logic busy_at_done);
    seen = 1'b0;
    busy_at_done = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (done_o) begin
        seen = 1'b1;
        busy_at_done = busy_o;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start_i = 1'b0; word_count_i = '0;
    byte_valid_i = 1'b1; byte_data_i = 8'hA5;
    #1 reset = 1'b0;
    #22;
    checks++;
    if ({byte_ready_o, mem_we_o, busy_o, done_o, error_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b required 00000", {byte_ready_o, mem_we_o, busy_o, done_o, error_o});
    end
    checks++;
    if (mem_addr_o !== 32'h0 || mem_data_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_addr_data: addr=%h data=%h required 0/0", mem_addr_o, mem_data_o);
    end
    @(negedge clk);
    byte_valid_i = 1'b0;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_two_word(input bit stall, input string tag);
    int wb, db, wwb;
    bit seen;
    logic bad;
    logic [7:0] s [0:7] = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    for (int i = 0; i < 8; i++) stream[i] = s[i];
    wb = wr_addr_q.size(); db = done_cnt; wwb = we_wide;
    cons_q.delete();
    do_start(6'd2);
    checks++;
    if (busy_o !== 1'b1 || byte_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL %s_start: busy=%0b ready=%0b required 1/1", tag, busy_o, byte_ready_o);
    end
    send_stream(8, stall);
    wait_done(50, seen, bad);
    checks++;
    if (!seen || bad !== 1'b0) begin
      errors++;
      $display("FAIL %s_done: seen=%0b busy_at_done=%0b required 1/0", tag, seen, bad);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (wr_addr_q.size() - wb != 2) begin
      errors++;
      $display("FAIL %s_write_count: got %0d required 2", tag, wr_addr_q.size() - wb);
    end else begin
      checks++;
      if (wr_addr_q[wb] !== 32'h0040_0000 || wr_data_q[wb] !== 32'h0050_0513) begin
        errors++;
        $display("FAIL %s_word0: %h@%h required 00500513@00400000", tag, wr_data_q[wb], wr_addr_q[wb]);
      end
      checks++;
      if (wr_addr_q[wb+1] !== 32'h0040_0004 || wr_data_q[wb+1] !== 32'h0010_0593) begin
        errors++;
        $display("FAIL %s_word1: %h@%h required 00100593@00400004", tag, wr_data_q[wb+1], wr_addr_q[wb+1]);
      end
    end
    checks++;
    if (done_cnt - db != 1 || we_wide != wwb) begin
      errors++;
      $display("FAIL %s_pulses: done=%0d wide_we=%0d required 1/0", tag, done_cnt - db, we_wide - wwb);
    end
    checks++;
    if (cons_q.size() != 8) begin
      errors++;
      $display("FAIL %s_consumed: got %0d bytes required 8", tag, cons_q.size());
    end else begin
      int bad_bytes = 0;
      for (int i = 0; i < 8; i++) if (cons_q[i] !== s[i]) bad_bytes++;
      checks++;
      if (bad_bytes != 0) begin
        errors++;
        $display("FAIL %s_byte_order: %0d bytes differ required 0", tag, bad_bytes);
      end
    end
  endtask

  task automatic test_illegal;
    int wb;
    bit seen;
    logic bad;
    wb = wr_addr_q.size();
    do_start(6'd0);
    checks++;
    if (error_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL illegal_zero: error=%0b busy=%0b required 1/0", error_o, busy_o);
    end
    do_start(6'd33);
    repeat (3) @(negedge clk);
    checks++;
    if (error_o !== 1'b1 || busy_o !== 1'b0 || byte_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL illegal_33: error=%0b busy=%0b ready=%0b required 1/0/0", error_o, busy_o, byte_ready_o);
    end
    checks++;
    if (wr_addr_q.size() != wb) begin
      errors++;
      $display("FAIL illegal_writes: got %0d required 0", wr_addr_q.size() - wb);
    end
    stream[0] = 8'h01; stream[1] = 8'h02; stream[2] = 8'h03; stream[3] = 8'h04;
    do_start(6'd1);
    checks++;
    if (error_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL illegal_clear: error=%0b busy=%0b required 0/1", error_o, busy_o);
    end
    send_stream(4, 1'b0);
    wait_done(50, seen, bad);
    repeat (2) @(negedge clk);
    checks++;
    if (!seen || wr_addr_q.size() != wb + 1 || wr_data_q[wr_data_q.size()-1] !== 32'h0403_0201) begin
      errors++;
      $display("FAIL illegal_recover: seen=%0b writes=%0d required 1/1", seen, wr_addr_q.size() - wb);
    end
  endtask

  task automatic test_reset_mid_word;
    int wb;
    bit seen;
    logic bad;
    wb = wr_addr_q.size();
    stream[0] = 8'hAA; stream[1] = 8'hBB;
    do_start(6'd1);
    send_stream(2, 1'b0);
    byte_valid_i = 1'b1;
    byte_data_i = 8'hCC;
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({byte_ready_o, mem_we_o, busy_o, done_o, error_o} !== 5'b0 || mem_addr_o !== 32'h0) begin
      errors++;
      $display("FAIL midreset_async: flags=%b addr=%h required 00000/0",
               {byte_ready_o, mem_we_o, busy_o, done_o, error_o}, mem_addr_o);
    end
    @(negedge clk);
    checks++;
    if (byte_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL midreset_ready: got %0b required 0", byte_ready_o);
    end
    byte_valid_i = 1'b0;
    reset = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (wr_addr_q.size() != wb) begin
      errors++;
      $display("FAIL midreset_nowrite: got %0d required 0", wr_addr_q.size() - wb);
    end
    stream[0] = 8'h11; stream[1] = 8'h22; stream[2] = 8'h33; stream[3] = 8'h44;
    do_start(6'd1);
    send_stream(4, 1'b0);
    wait_done(50, seen, bad);
    repeat (2) @(negedge clk);
    checks++;
    if (!seen || wr_addr_q.size() != wb + 1) begin
      errors++;
      $display("FAIL midreset_session: seen=%0b writes=%0d required 1/1", seen, wr_addr_q.size() - wb);
    end else begin
      checks++;
      if (wr_addr_q[wb] !== 32'h0040_0000 || wr_data_q[wb] !== 32'h4433_2211) begin
        errors++;
        $display("FAIL midreset_word: %h@%h required 44332211@00400000", wr_data_q[wb], wr_addr_q[wb]);
      end
    end
  endtask

  task automatic test_full_depth;
    int wb, db, seq_bad;
    bit seen;
    logic bad;
    for (int i = 0; i < 128; i++) stream[i] = 8'(i);
    wb = wr_addr_q.size(); db = done_cnt;
    do_start(6'd32);
    fork
      send_stream(128, 1'b0);
      begin
        repeat (40) @(negedge clk);
        start_i = 1'b1;
        word_count_i = 6'd0;
        @(negedge clk);
        start_i = 1'b0;
      end
    join
    wait_done(50, seen, bad);
    repeat (10) @(negedge clk);
    checks++;
    if (!seen || wr_addr_q.size() - wb != 32 || done_cnt - db != 1) begin
      errors++;
      $display("FAIL full_counts: seen=%0b writes=%0d done=%0d required 1/32/1",
               seen, wr_addr_q.size() - wb, done_cnt - db);
    end else begin
      seq_bad = 0;
      for (int w = 0; w < 32; w++) begin
        logic [31:0] ea, ed;
        ea = 32'h0040_0000 + 32'(4 * w);
        ed = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
        if (wr_addr_q[wb+w] !== ea || wr_data_q[wb+w] !== ed) seq_bad++;
      end
      checks++;
      if (seq_bad != 0) begin
        errors++;
        $display("FAIL full_sequence: %0d words wrong required 0", seq_bad);
      end
      checks++;
      if (wr_addr_q[wb+31] !== 32'h0040_007C || wr_data_q[wb+31] !== 32'h7F7E_7D7C) begin
        errors++;
        $display("FAIL full_last: %h@%h required 7F7E7D7C@0040007C", wr_data_q[wb+31], wr_addr_q[wb+31]);
      end
    end
    checks++;
    if (busy_o !== 1'b0 || error_o !== 1'b0) begin
      errors++;
      $display("FAIL full_ignored_start: busy=%0b error=%0b required 0/0", busy_o, error_o);
    end
  endtask

  initial begin
    test_reset();
    test_two_word(1'b0, "two_word");
    test_two_word(1'b1, "stalled");
    test_illegal();
    test_reset_mid_word();
    test_full_depth();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
